// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubble insertion, taken-branch flush and
// global freeze while data memory is busy, with a saturating stall counter.
module hazard_unit #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       sel_rs1_i,
  input  logic [4:0]       sel_rs2_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic [4:0]       execute_sel_rd_i,
  input  logic             execute_is_load_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             stall_fetch_o,
  output logic             stall_decode_o,
  output logic             bubble_execute_o,
  output logic             flush_decode_o,
  output logic             freeze_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [1:0]       hazard_state_o
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_inc;
  logic                in_wait;
  logic                mem_busy;
  logic                lu_hit;

  assign hazard_state_o = state;
  assign in_wait        = (state == MEM_WAIT);
  assign wait_inc       = (wait_cnt < WAIT_MAX) ? wait_cnt + WAIT_W'(1) : wait_cnt;

  // Once frozen, only dmem_ready_i matters; the request may have been dropped.
  assign mem_busy = in_wait ? ~dmem_ready_i : (dmem_req_i & ~dmem_ready_i);

  assign lu_hit = execute_is_load_i && (execute_sel_rd_i != 5'd0) &&
                  ((rs1_used_i && (sel_rs1_i == execute_sel_rd_i)) ||
                   (rs2_used_i && (sel_rs2_i == execute_sel_rd_i)));

  // Mealy control: memory freeze beats branch flush beats load-use stall.
  always_comb begin
    state_nxt        = RUN;
    stall_fetch_o    = 1'b0;
    stall_decode_o   = 1'b0;
    bubble_execute_o = 1'b0;
    flush_decode_o   = 1'b0;
    freeze_o         = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        freeze_o  = 1'b1;
        state_nxt = MEM_WAIT;
      end else if (branch_taken_i) begin
        flush_decode_o   = 1'b1;
        bubble_execute_o = 1'b1;
      end else if (lu_hit && (state != LU_STALL)) begin
        stall_fetch_o    = 1'b1;
        stall_decode_o   = 1'b1;
        bubble_execute_o = 1'b1;
        state_nxt        = LU_STALL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
      stall_count_o <= '0;
    end else begin
      state <= state_nxt;
      if (in_wait && !dmem_ready_i) begin
        wait_cnt <= wait_inc;
        if (wait_inc == WAIT_MAX) mem_timeout_o <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if ((freeze_o || stall_fetch_o) && (stall_count_o != '1))
        stall_count_o <= stall_count_o + CNT_W'(1);
    end
  end

endmodule
